// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the N-to-1 streaming multiplexer.
package stream_mux_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

endpackage

// File: rtl/stream_mux_nto1_rr_arbiter.sv
// Round-robin arbiter: first requesting channel at or after ptr, modulo N_CH.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int N_CH  = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] grant,
  output logic             grant_vld
);

  int unsigned idx;

  // Scan from farthest to nearest so the channel closest to ptr wins.
  always_comb begin
    grant     = '0;
    grant_vld = |req;
    idx       = 0;
    for (int unsigned k = N_CH; k > 0; k--) begin
      idx = (32'(ptr) + k - 1) % N_CH;
      if (req[idx[SEL_W-1:0]]) grant = SEL_W'(idx);
    end
  end

endmodule

// File: rtl/stream_mux_nto1.sv
// N-to-1 valid/ready stream multiplexer with packet locking and registered output.
module stream_mux_nto1
  import stream_mux_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int WIDTH = 8,
  parameter  int MODE  = 1,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH-1:0]       in_last,
  output logic [N_CH-1:0]       in_ready,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [SEL_W-1:0]      out_ch,
  input  logic                  out_ready
);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  lock_ch_q, rr_ptr_q;
  logic [SEL_W-1:0]  pick, grant;
  logic              pick_vld, grant_vld;
  logic              load_en, xfer, g_last;
  logic [WIDTH-1:0]  g_data;

  generate
    if (MODE == MODE_RR) begin : g_rr
      rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr_q),
        .grant     (pick),
        .grant_vld (pick_vld)
      );
      logic unused_sel;
      assign unused_sel = ^sel;
    end else begin : g_sel
      assign pick     = sel;
      assign pick_vld = (32'(sel) < N_CH);
      logic unused_ptr;
      assign unused_ptr = ^rr_ptr_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (xfer) begin
      if (state_q == ST_LOCKED && g_last)  state_d = ST_IDLE;
      if (state_q == ST_IDLE   && !g_last) state_d = ST_LOCKED;
    end
  end

  // Channel mux is a compare loop so an out-of-range sel never forms an illegal part-select.
  always_comb begin
    grant     = (state_q == ST_LOCKED) ? lock_ch_q : pick;
    grant_vld = (state_q == ST_LOCKED) ? 1'b1 : pick_vld;
    load_en   = !out_valid || out_ready;
    in_ready  = '0;
    g_data    = '0;
    g_last    = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (32'(grant) == i) begin
        g_data = in_data[i*WIDTH +: WIDTH];
        g_last = in_last[i];
        if (load_en && grant_vld && !rst) in_ready[i] = 1'b1;
      end
    end
    xfer = |(in_valid & in_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_ch_q <= '0;
      rr_ptr_q  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else begin
      if (xfer && state_q == ST_IDLE && !g_last) lock_ch_q <= grant;
      if (xfer && g_last)
        rr_ptr_q <= (32'(grant) == N_CH - 1) ? '0 : grant + 1'b1;
      if (load_en) begin
        out_valid <= xfer;
        if (xfer) begin
          out_data <= g_data;
          out_last <= g_last;
          out_ch   <= grant;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_nto1.sv
// Bench for stream_mux_nto1: one MODE 0 and one MODE 1 instance against a cycle model.
module tb_stream_mux_nto1;

  logic        clk, rst;
  logic [31:0] in_data  [2];
  logic [3:0]  in_valid [2];
  logic [3:0]  in_last  [2];
  logic [1:0]  sel      [2];
  logic        out_ready[2];

  logic [3:0] ir0, ir1;
  logic [7:0] od0, od1;
  logic       ov0, ov1, ol0, ol1;
  logic [1:0] och0, och1;

  int checks = 0;
  int errors = 0;

  stream_mux_nto1 #(.N_CH(4), .WIDTH(8), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_last(in_last[0]), .in_ready(ir0), .sel(sel[0]), .out_data(od0),
    .out_valid(ov0), .out_last(ol0), .out_ch(och0), .out_ready(out_ready[0])
  );

  stream_mux_nto1 #(.N_CH(4), .WIDTH(8), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_last(in_last[1]), .in_ready(ir1), .sel(sel[1]), .out_data(od1),
    .out_valid(ov1), .out_last(ol1), .out_ch(och1), .out_ready(out_ready[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t got %h expected %h", nm, n, $time, act, exp);
    end
  endtask

  // Model state: what out_* must hold, plus lock and round-robin pointer.
  bit         m_ov [2];
  logic [7:0] m_od [2];
  bit         m_ol [2];
  int         m_och[2];
  bit         m_lk [2];
  int         m_lch[2];
  int         m_ptr[2];
  bit         armed[2];

  task automatic model_step(input int n, input int mode, input logic [3:0] ir,
                            input logic ov, input logic [7:0] od, input logic ol,
                            input logic [1:0] och);
    int g;
    bit gv, load;
    logic [3:0] er;
    logic [3:0] one;
    one = 4'b0001;
    if (armed[n]) begin
      chk("out_valid", n, 32'(ov), 32'(m_ov[n]));
      if (m_ov[n]) begin
        chk("out_data", n, 32'(od), 32'(m_od[n]));
        chk("out_last", n, 32'(ol), 32'(m_ol[n]));
        chk("out_ch", n, 32'(och), 32'(m_och[n]));
      end
    end
    g    = 0;
    gv   = 1'b0;
    load = !m_ov[n] || out_ready[n];
    if (m_lk[n]) begin
      g  = m_lch[n];
      gv = 1'b1;
    end else if (mode == 0) begin
      g  = int'(sel[n]);
      gv = (g < 4);
    end else begin
      gv = |in_valid[n];
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_ptr[n] + k) % 4;
        if (in_valid[n][c]) begin
          g = c;
          break;
        end
      end
    end
    er = (!rst && load && gv) ? (one << g) : 4'b0000;
    chk("in_ready", n, 32'(ir), 32'(er));
    if (rst) begin
      m_ov[n] = 0; m_od[n] = 8'h00; m_ol[n] = 0; m_och[n] = 0;
      m_lk[n] = 0; m_lch[n] = 0; m_ptr[n] = 0; armed[n] = 1;
    end else if (load) begin
      m_ov[n] = |(er & in_valid[n]);
      if (m_ov[n]) begin
        m_od[n]  = in_data[n][g*8 +: 8];
        m_ol[n]  = in_last[n][g];
        m_och[n] = g;
        if (in_last[n][g]) begin
          m_lk[n]  = 0;
          m_ptr[n] = (g + 1) % 4;
        end else if (!m_lk[n]) begin
          m_lk[n]  = 1;
          m_lch[n] = g;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    model_step(0, 0, ir0, ov0, od0, ol0, och0);
    model_step(1, 1, ir1, ov1, od1, ol1, och1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] t4_d[4];
  int         t4_c[4];
  logic [3:0] t4_r[4];
  logic [3:0] onehot;

  initial begin
    t4_d = '{8'h11, 8'h12, 8'h13, 8'hC2};
    t4_c = '{1, 1, 1, 2};
    t4_r = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};

    rst = 1'b1;
    for (int n = 0; n < 2; n++) begin
      in_valid[n] = 4'hF; in_last[n] = 4'hF; in_data[n] = 32'hFFFF_FFFF;
      sel[n] = 2'd2; out_ready[n] = 1'b1;
    end

    // Reset with every input active
    repeat (2) begin
      @(negedge clk);
      chk("t1_ov", 0, 32'(ov0), 0);  chk("t1_ov", 1, 32'(ov1), 0);
      chk("t1_od", 0, 32'(od0), 0);  chk("t1_od", 1, 32'(od1), 0);
      chk("t1_ch", 0, 32'(och0), 0); chk("t1_ch", 1, 32'(och1), 0);
      chk("t1_rdy", 0, 32'(ir0), 0); chk("t1_rdy", 1, 32'(ir1), 0);
    end

    // External select, single-beat packet
    step();
    rst = 1'b0;
    in_valid[1] = 4'h0;
    in_valid[0] = 4'hF; in_data[0] = 32'hA3A2A1A0; in_last[0] = 4'hF; sel[0] = 2'd2;
    @(negedge clk); chk("t2_rdy", 0, 32'(ir0), 32'b0100);
    step();
    in_valid[0] = 4'h0;
    @(negedge clk);
    chk("t2_od", 0, 32'(od0), 32'hA2); chk("t2_ch", 0, 32'(och0), 2);
    chk("t2_last", 0, 32'(ol0), 1);    chk("t2_ov", 0, 32'(ov0), 1);

    // External select changing mid-packet is ignored
    step();
    in_valid[0] = 4'hF; in_last[0] = 4'h0; sel[0] = 2'd1; in_data[0] = 32'hB3B2B1B0;
    @(negedge clk); chk("lk_rdy0", 0, 32'(ir0), 32'b0010);
    step();
    sel[0] = 2'd3; in_last[0] = 4'b0010; in_data[0] = 32'hC3C2C1C0;
    @(negedge clk);
    chk("lk_rdy1", 0, 32'(ir0), 32'b0010); chk("lk_od1", 0, 32'(od0), 32'hB1);
    chk("lk_ch1", 0, 32'(och0), 1);
    step();
    in_last[0] = 4'hF;
    @(negedge clk);
    chk("lk_rdy2", 0, 32'(ir0), 32'b1000); chk("lk_od2", 0, 32'(od0), 32'hC1);
    chk("lk_last2", 0, 32'(ol0), 1);
    step();
    in_valid[0] = 4'h0;
    @(negedge clk); chk("lk_od3", 0, 32'(od0), 32'hC3); chk("lk_ch3", 0, 32'(och0), 3);

    // Round-robin, all channels valid, single-beat packets
    step();
    in_valid[1] = 4'hF; in_last[1] = 4'hF; in_data[1] = 32'h33221100;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      onehot = 4'b0001 << (k % 4);
      chk("t3_rdy", 1, 32'(ir1), 32'(onehot));
      if (k > 0) begin
        chk("t3_ch", 1, 32'(och1), 32'((k - 1) % 4));
        chk("t3_ov", 1, 32'(ov1), 1);
      end
      step();
    end

    // Round-robin, ch1 three-beat packet holds the lock
    in_valid[1] = 4'b0111; in_last[1] = 4'b0101; in_data[1] = 32'h00C21100;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        in_data[1][15:8] = 8'(8'h11 + k);
        in_last[1][1]    = (k == 2);
      end else begin
        in_valid[1] = 4'h0;
      end
      @(negedge clk);
      if (k < 4) chk("t4_rdy", 1, 32'(ir1), 32'(t4_r[k]));
      if (k > 0) begin
        chk("t4_od", 1, 32'(od1), 32'(t4_d[k-1]));
        chk("t4_ch", 1, 32'(och1), 32'(t4_c[k-1]));
      end
      step();
    end

    // Backpressure holds the output stage
    in_valid[1] = 4'b0001; in_data[1] = 32'h0000005C; in_last[1] = 4'b0001;
    @(negedge clk); chk("t5_rdy0", 1, 32'(ir1), 32'b0001);
    step();
    out_ready[1] = 1'b0; in_data[1][7:0] = 8'h5D;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_hold_od", 1, 32'(od1), 32'h5C); chk("t5_hold_ov", 1, 32'(ov1), 1);
      chk("t5_hold_rdy", 1, 32'(ir1), 0);
      step();
    end
    out_ready[1] = 1'b1;
    @(negedge clk); chk("t5_rel_od", 1, 32'(od1), 32'h5C); chk("t5_rel_rdy", 1, 32'(ir1), 32'b0001);
    step();
    in_valid[1] = 4'h0;
    @(negedge clk); chk("t5_next_od", 1, 32'(od1), 32'h5D); chk("t5_next_ov", 1, 32'(ov1), 1);
    step();

    // Reset in the middle of a ch3 packet
    in_valid[1] = 4'b1001; in_last[1] = 4'b0001; in_data[1] = 32'h3100000A;
    @(negedge clk); chk("t6_rdy0", 1, 32'(ir1), 32'b1000);
    step();
    in_data[1][31:24] = 8'h32;
    @(negedge clk);
    chk("t6_rdy1", 1, 32'(ir1), 32'b1000); chk("t6_od1", 1, 32'(od1), 32'h31);
    chk("t6_ch1", 1, 32'(och1), 3);
    step();
    rst = 1'b1; in_data[1][31:24] = 8'h33;
    @(negedge clk); chk("t6_rst_rdy", 1, 32'(ir1), 0); chk("t6_od2", 1, 32'(od1), 32'h32);
    step();
    rst = 1'b0;
    @(negedge clk); chk("t6_ov_clr", 1, 32'(ov1), 0); chk("t6_rdy_after", 1, 32'(ir1), 32'b0001);
    step();
    in_valid[1] = 4'h0;
    @(negedge clk); chk("t6_od_after", 1, 32'(od1), 32'h0A); chk("t6_ch_after", 1, 32'(och1), 0);

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
